// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, write/read FSM state encodings
// and the byte-strobe merge helper used by the register file.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between the upstream master (m1) and the register file.
interface axi_lite_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank with independent write/read FSMs.
// Define REGFILE_ID_REG_EN to make reg 0 a read-only ID register returning ID_VALUE.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'hA0D1_0001
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_areset,
  axi_lite_regfile_if.slave        s_axi,
  output logic [NUM_REGS*32-1:0]   q_regs
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SW = DATA_WIDTH / 8;
`ifdef REGFILE_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  wr_state_e             wr_state_r, wr_state_nxt_s;
  logic                  awready_r, awready_nxt_s, wready_r, wready_nxt_s;
  logic                  bvalid_r, bvalid_nxt_s, aw_done_r, aw_done_nxt_s, w_done_r, w_done_nxt_s;
  logic [1:0]            bresp_r, bresp_nxt_s;
  logic [IW-1:0]         aw_idx_r, aw_idx_nxt_s, wr_idx_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_nxt_s, wr_data_s;
  logic [SW-1:0]         wstrb_r, wstrb_nxt_s, wr_strb_s;
  logic                  aw_hs_s, w_hs_s, wr_ok_s, wr_commit_s, wr_en_s;
  logic [NUM_REGS-1:0]   wr_sel_s;

  rd_state_e             rd_state_r, rd_state_nxt_s;
  logic                  arready_r, arready_nxt_s, rvalid_r, rvalid_nxt_s, ar_hs_s, rd_ok_s;
  logic [1:0]            rresp_r, rresp_nxt_s;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_nxt_s, rd_word_s;
  logic [IW-1:0]         rd_idx_s;

  // A beat arriving this cycle takes precedence over the latched copy.
  assign aw_hs_s   = s_axi.awvalid & awready_r;
  assign w_hs_s    = s_axi.wvalid & wready_r;
  assign wr_idx_s  = aw_hs_s ? s_axi.awaddr[ADDR_WIDTH-1:2] : aw_idx_r;
  assign wr_data_s = w_hs_s ? s_axi.wdata : wdata_r;
  assign wr_strb_s = w_hs_s ? s_axi.wstrb : wstrb_r;
  assign wr_ok_s   = (wr_idx_s < IW'(NUM_REGS)) && !(ID_EN && (wr_idx_s == {IW{1'b0}}));
  assign wr_en_s   = wr_commit_s & wr_ok_s;

  // Write FSM next-state and next-output logic.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    awready_nxt_s  = awready_r;
    wready_nxt_s   = wready_r;
    bvalid_nxt_s   = bvalid_r;
    bresp_nxt_s    = bresp_r;
    aw_done_nxt_s  = aw_done_r;
    w_done_nxt_s   = w_done_r;
    aw_idx_nxt_s   = aw_idx_r;
    wdata_nxt_s    = wdata_r;
    wstrb_nxt_s    = wstrb_r;
    wr_commit_s    = 1'b0;
    case (wr_state_r)
      WR_IDLE: begin
        if ((aw_hs_s || aw_done_r) && (w_hs_s || w_done_r)) begin
          wr_commit_s    = 1'b1;
          awready_nxt_s  = 1'b0;
          wready_nxt_s   = 1'b0;
          bvalid_nxt_s   = 1'b1;
          bresp_nxt_s    = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
          aw_done_nxt_s  = 1'b0;
          w_done_nxt_s   = 1'b0;
          wr_state_nxt_s = WR_RESP;
        end else begin
          aw_done_nxt_s = aw_done_r | aw_hs_s;
          awready_nxt_s = awready_r & ~aw_hs_s;
          aw_idx_nxt_s  = wr_idx_s;
          w_done_nxt_s  = w_done_r | w_hs_s;
          wready_nxt_s  = wready_r & ~w_hs_s;
          wdata_nxt_s   = wr_data_s;
          wstrb_nxt_s   = wr_strb_s;
        end
      end
      WR_RESP: begin
        if (s_axi.bready) begin
          bvalid_nxt_s   = 1'b0;
          awready_nxt_s  = 1'b1;
          wready_nxt_s   = 1'b1;
          wr_state_nxt_s = WR_IDLE;
        end else begin
          bvalid_nxt_s   = 1'b1;
        end
      end
      default: begin
        bvalid_nxt_s   = 1'b0;
        awready_nxt_s  = 1'b1;
        wready_nxt_s   = 1'b1;
        aw_done_nxt_s  = 1'b0;
        w_done_nxt_s   = 1'b0;
        wr_state_nxt_s = WR_IDLE;
      end
    endcase
  end

  // One-hot register select for the committing write.
  always_comb begin
    wr_sel_s = {NUM_REGS{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      wr_sel_s[k] = wr_en_s && (wr_idx_s[RW-1:0] == RW'(k));
    end
  end

  // Read data is sampled from the current array, so a same-cycle write is not yet visible.
  assign ar_hs_s  = s_axi.arvalid & arready_r;
  assign rd_idx_s = s_axi.araddr[ADDR_WIDTH-1:2];
  assign rd_ok_s  = rd_idx_s < IW'(NUM_REGS);

  // Read FSM next-state and next-output logic.
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    arready_nxt_s  = arready_r;
    rvalid_nxt_s   = rvalid_r;
    rresp_nxt_s    = rresp_r;
    rdata_nxt_s    = rdata_r;
    if (!rd_ok_s) begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end else if (ID_EN && (rd_idx_s == {IW{1'b0}})) begin
      rd_word_s = ID_VALUE;
    end else begin
      rd_word_s = regs_r[rd_idx_s[RW-1:0]];
    end
    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rdata_nxt_s    = rd_word_s;
          rresp_nxt_s    = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
          rvalid_nxt_s   = 1'b1;
          arready_nxt_s  = 1'b0;
          rd_state_nxt_s = RD_DATA;
        end else begin
          rvalid_nxt_s   = 1'b0;
        end
      end
      RD_DATA: begin
        if (s_axi.rready) begin
          rvalid_nxt_s   = 1'b0;
          arready_nxt_s  = 1'b1;
          rd_state_nxt_s = RD_IDLE;
        end else begin
          rvalid_nxt_s   = 1'b1;
        end
      end
      default: begin
        rvalid_nxt_s   = 1'b0;
        arready_nxt_s  = 1'b1;
        rd_state_nxt_s = RD_IDLE;
      end
    endcase
  end

  // State and output registers for both FSMs plus the register array.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state_r <= WR_IDLE;
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      aw_idx_r   <= {IW{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      wstrb_r    <= {SW{1'b0}};
      rd_state_r <= RD_IDLE;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
      rdata_r    <= {DATA_WIDTH{1'b0}};
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      wr_state_r <= wr_state_nxt_s;
      awready_r  <= awready_nxt_s;
      wready_r   <= wready_nxt_s;
      bvalid_r   <= bvalid_nxt_s;
      bresp_r    <= bresp_nxt_s;
      aw_done_r  <= aw_done_nxt_s;
      w_done_r   <= w_done_nxt_s;
      aw_idx_r   <= aw_idx_nxt_s;
      wdata_r    <= wdata_nxt_s;
      wstrb_r    <= wstrb_nxt_s;
      rd_state_r <= rd_state_nxt_s;
      arready_r  <= arready_nxt_s;
      rvalid_r   <= rvalid_nxt_s;
      rresp_r    <= rresp_nxt_s;
      rdata_r    <= rdata_nxt_s;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_sel_s[k]) begin
          regs_r[k] <= apply_strobe(regs_r[k], wr_data_s, wr_strb_s);
        end
      end
    end
  end

  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rresp   = rresp_r;
  assign s_axi.rdata   = rdata_r;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_q
    assign q_regs[32*k +: 32] = (ID_EN && (k == 0)) ? ID_VALUE : regs_r[k];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile (honours REGFILE_ID_REG_EN when defined).
`timescale 1ns/1ps
module tb_axi_lite_regfile;

  logic         clk;
  logic         areset;
  logic [255:0] q_regs;
  int           checks;
  int           errors;

  axi_lite_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_lite_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(8), .ID_VALUE(32'hA0D1_0001)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi        (bus),
    .q_regs       (q_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single write with AW and W together and bready held high; returns the B response.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    ok = 1'b0;
    resp = 2'b11;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; bus.bready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      if (bus.bvalid) begin
        resp = bus.bresp;
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output bit ok);
    ok = 1'b0;
    d = 32'hFFFF_FFFF;
    resp = 2'b11;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.arvalid = 1'b0;
      if (bus.rvalid) begin
        d = bus.rdata;
        resp = bus.rresp;
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b expected 111", {bus.awready, bus.wready, bus.arready});
    end
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin
      errors++; $display("FAIL reset_valid_resp: got %b expected 000000", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp});
    end
    checks++;
    if (q_regs !== 256'd0 || bus.rdata !== 32'd0) begin
      errors++; $display("FAIL reset_regs: q_regs %h rdata %h expected all zero", q_regs, bus.rdata);
    end
  endtask

  task automatic test_write_read_same_cycle();
    logic [31:0] d; logic [1:0] r; bit ok;
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0017; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
      errors++; $display("FAIL wr_same_cycle_b: bvalid %b bresp %b awready %b wready %b expected 1 00 0 0",
                         bus.bvalid, bus.bresp, bus.awready, bus.wready);
    end
    tick();
    checks++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || q_regs[32 +: 32] !== 32'h17) begin
      errors++; $display("FAIL wr_same_cycle_done: bvalid %b awready %b reg1 %h expected 0 1 00000017",
                         bus.bvalid, bus.awready, q_regs[32 +: 32]);
    end
    bus.araddr = 8'h04; bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h17 || bus.rresp !== 2'b00 || bus.arready !== 1'b0) begin
      errors++; $display("FAIL rd_latency: rvalid %b rdata %h rresp %b arready %b expected 1 00000017 00 0",
                         bus.rvalid, bus.rdata, bus.rresp, bus.arready);
    end
    tick();
    checks++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      errors++; $display("FAIL rd_return: rvalid %b arready %b expected 0 1", bus.rvalid, bus.arready);
    end
    axi_read(8'h07, d, r, ok);
    checks++;
    if (!ok || d !== 32'h17 || r !== 2'b00) begin
      errors++; $display("FAIL rd_low_bits_ignored: ok %0d rdata %h rresp %b expected 1 00000017 00", ok, d, r);
    end
  endtask

  task automatic test_w_before_aw();
    bus.wdata = 32'hAABB_CCDD; bus.wstrb = 4'h5; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    checks++;
    if (bus.wready !== 1'b0 || bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
      errors++; $display("FAIL w_first_latch: wready %b awready %b bvalid %b expected 0 1 0",
                         bus.wready, bus.awready, bus.bvalid);
    end
    tick();
    tick();
    checks++;
    if (q_regs[128 +: 32] !== 32'd0 || bus.bvalid !== 1'b0) begin
      errors++; $display("FAIL w_first_no_commit: reg4 %h bvalid %b expected 00000000 0", q_regs[128 +: 32], bus.bvalid);
    end
    bus.awaddr = 8'h10; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || q_regs[128 +: 32] !== 32'h00BB_00DD) begin
      errors++; $display("FAIL w_first_commit: bvalid %b bresp %b reg4 %h expected 1 00 00bb00dd",
                         bus.bvalid, bus.bresp, q_regs[128 +: 32]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; bit ok;
    logic [255:0] exp_q;
    exp_q = 256'd0;
    exp_q[32 +: 32]  = 32'h0000_0017;
    exp_q[128 +: 32] = 32'h00BB_00DD;
    axi_write(8'h20, 32'hDEAD_BEEF, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b10 || q_regs !== exp_q) begin
      errors++; $display("FAIL oor_write: ok %0d bresp %b q_regs %h expected 1 10 %h", ok, r, q_regs, exp_q);
    end
    axi_read(8'h20, d, r, ok);
    checks++;
    if (!ok || r !== 2'b10 || d !== 32'd0) begin
      errors++; $display("FAIL oor_read: ok %0d rresp %b rdata %h expected 1 10 00000000", ok, r, d);
    end
    axi_write(8'h04, 32'hFFFF_FFFF, 4'h0, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || q_regs[32 +: 32] !== 32'h17) begin
      errors++; $display("FAIL zero_strobe: ok %0d bresp %b reg1 %h expected 1 00 00000017", ok, r, q_regs[32 +: 32]);
    end
    axi_write(8'h1C, 32'h1234_5678, 4'hF, r, ok);
    axi_read(8'h1C, d, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || d !== 32'h1234_5678) begin
      errors++; $display("FAIL top_index: ok %0d rresp %b rdata %h expected 1 00 12345678", ok, r, d);
    end
  endtask

  task automatic test_backpressure();
    bus.awaddr = 8'h08; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0055; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
        errors++; $display("FAIL b_hold[%0d]: bvalid %b awready %b expected 1 0", i, bus.bvalid, bus.awready);
      end
      tick();
    end
    bus.bready = 1'b1;
    tick();
    checks++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
      errors++; $display("FAIL b_release: bvalid %b awready %b expected 0 1", bus.bvalid, bus.awready);
    end
    bus.araddr = 8'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h55 || bus.arready !== 1'b0) begin
        errors++; $display("FAIL r_hold[%0d]: rvalid %b rdata %h arready %b expected 1 00000055 0",
                           i, bus.rvalid, bus.rdata, bus.arready);
      end
      tick();
    end
    bus.rready = 1'b1;
    tick();
    checks++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      errors++; $display("FAIL r_release: rvalid %b arready %b expected 0 1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; bit ok;
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0099; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    bus.araddr = 8'h0C; bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1 || bus.rdata !== 32'd0 || q_regs[96 +: 32] !== 32'h99) begin
      errors++; $display("FAIL rw_collide: bvalid %b rvalid %b rdata %h reg3 %h expected 1 1 00000000 00000099",
                         bus.bvalid, bus.rvalid, bus.rdata, q_regs[96 +: 32]);
    end
    tick();
    axi_read(8'h0C, d, r, ok);
    checks++;
    if (!ok || d !== 32'h99 || r !== 2'b00) begin
      errors++; $display("FAIL rw_after: ok %0d rdata %h rresp %b expected 1 00000099 00", ok, d, r);
    end
  endtask

  task automatic test_id_reg();
    logic [31:0] d; logic [1:0] r, wr; bit ok, ok2;
    logic [31:0] exp_d; logic [1:0] exp_r;
`ifdef REGFILE_ID_REG_EN
    exp_d = 32'hA0D1_0001; exp_r = 2'b10;
`else
    exp_d = 32'h0000_001E; exp_r = 2'b00;
`endif
    axi_write(8'h00, 32'h0000_001E, 4'hF, wr, ok);
    axi_read(8'h00, d, r, ok2);
    checks++;
    if (!ok || !ok2 || wr !== exp_r || d !== exp_d || r !== 2'b00 || q_regs[31:0] !== exp_d) begin
      errors++; $display("FAIL reg0: bresp %b rdata %h rresp %b q0 %h expected %b %h 00 %h",
                         wr, d, r, q_regs[31:0], exp_r, exp_d, exp_d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    bus.awaddr = 8'h00; bus.awvalid = 1'b0; bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = 8'h00; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    test_write_read_same_cycle();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_id_reg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
